// File: rtl/key_turn_arbiter.sv
// Turn-based command arbiter for a two-player board game: merges the active
// player's key events into a single ready/valid command stream with undo history.
module key_turn_arbiter #(
  parameter int REPEAT_TICKS = 10,
  parameter int CNT_WIDTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100hz,
  input  logic [3:0] red_s,
  input  logic [3:0] red_l,
  input  logic       red_sel,
  input  logic [3:0] blk_s,
  input  logic [3:0] blk_l,
  input  logic       blk_sel,
  input  logic       undo_req,
  input  logic       restart_req,
  input  logic       move_done,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic       cmd_player,
  output logic       turn,
  output logic [7:0] history_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [2:0]           OP_SEL   = 3'd4;
  localparam logic [2:0]           OP_UNDO  = 3'd5;
  localparam logic [CNT_WIDTH-1:0] REP_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 player_q, player_d;
  logic                 turn_q, turn_d;
  logic [7:0]           hist_q, hist_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]           rep_dir_q, rep_dir_d;
  logic                 rep_held_q, rep_held_d;

  logic [3:0] cur_s;
  logic [3:0] cur_l;
  logic       cur_sel;
  logic       any_l;
  logic [1:0] dir_now;
  logic       rep_fire;
  logic       ev_valid;
  logic [2:0] ev_op;
  logic       pend_eff;
  logic [7:0] hist_inc;
  logic [7:0] hist_dec;

  // Only the player whose turn it is can drive commands or auto-repeat.
  always_comb begin
    cur_s   = turn_q ? blk_s   : red_s;
    cur_l   = turn_q ? blk_l   : red_l;
    cur_sel = turn_q ? blk_sel : red_sel;
    any_l   = |cur_l;
    if (cur_l[0]) begin
      dir_now = 2'd0;
    end else if (cur_l[1]) begin
      dir_now = 2'd1;
    end else if (cur_l[2]) begin
      dir_now = 2'd2;
    end else begin
      dir_now = 2'd3;
    end
  end

  assign rep_fire = any_l && rep_held_q && (dir_now == rep_dir_q) &&
                    tick_100hz && (rep_cnt_q == REP_LAST);

  always_comb begin
    ev_valid = 1'b0;
    ev_op    = 3'd0;
    if (undo_req && (hist_q != 8'd0)) begin
      ev_valid = 1'b1;
      ev_op    = OP_UNDO;
    end else if (cur_sel) begin
      ev_valid = 1'b1;
      ev_op    = OP_SEL;
    end else if (cur_s[0]) begin
      ev_valid = 1'b1;
      ev_op    = 3'd0;
    end else if (cur_s[1]) begin
      ev_valid = 1'b1;
      ev_op    = 3'd1;
    end else if (cur_s[2]) begin
      ev_valid = 1'b1;
      ev_op    = 3'd2;
    end else if (cur_s[3]) begin
      ev_valid = 1'b1;
      ev_op    = 3'd3;
    end else if (rep_fire) begin
      ev_valid = 1'b1;
      ev_op    = {1'b0, dir_now};
    end
  end

  assign hist_inc = (hist_q == 8'hFF) ? hist_q : hist_q + 8'd1;
  assign hist_dec = (hist_q == 8'h00) ? hist_q : hist_q - 8'd1;
  // A move_done landing on the handshake edge itself counts as pending.
  assign pend_eff = pend_q | move_done;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    player_d = player_q;
    turn_d   = turn_q;
    hist_d   = hist_q;
    pend_d   = pend_q;

    if (state_q == IDLE) begin
      if (move_done) begin
        turn_d = ~turn_q;
        hist_d = hist_inc;
      end
      if (ev_valid) begin
        op_d     = ev_op;
        player_d = turn_q;
        state_d  = ISSUE;
      end
    end else begin
      if (cmd_ready) begin
        state_d = IDLE;
        pend_d  = 1'b0;
        // Undo and a deferred move cancel each other out.
        if (op_q == OP_UNDO) begin
          if (!pend_eff) begin
            turn_d = ~turn_q;
            hist_d = hist_dec;
          end
        end else if (pend_eff) begin
          turn_d = ~turn_q;
          hist_d = hist_inc;
        end
      end else if (move_done) begin
        pend_d = 1'b1;
      end
    end

    if (restart_req) begin
      state_d  = IDLE;
      op_d     = 3'd0;
      player_d = 1'b0;
      turn_d   = 1'b0;
      hist_d   = 8'd0;
      pend_d   = 1'b0;
    end
  end

  // Repeat timer restarts whenever the held direction or owner changes.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    rep_dir_d  = rep_dir_q;
    rep_held_d = rep_held_q;
    if (restart_req || !any_l || (turn_d != turn_q)) begin
      rep_cnt_d  = '0;
      rep_held_d = 1'b0;
    end else if (!rep_held_q || (dir_now != rep_dir_q)) begin
      rep_cnt_d  = '0;
      rep_held_d = 1'b1;
      rep_dir_d  = dir_now;
    end else if (tick_100hz) begin
      rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      player_q   <= 1'b0;
      turn_q     <= 1'b0;
      hist_q     <= 8'd0;
      pend_q     <= 1'b0;
      rep_cnt_q  <= '0;
      rep_dir_q  <= 2'd0;
      rep_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      player_q   <= player_d;
      turn_q     <= turn_d;
      hist_q     <= hist_d;
      pend_q     <= pend_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_dir_q  <= rep_dir_d;
      rep_held_q <= rep_held_d;
    end
  end

  assign cmd_valid   = (state_q == ISSUE);
  assign cmd_op      = op_q;
  assign cmd_player  = player_q;
  assign turn        = turn_q;
  assign history_cnt = hist_q;

endmodule

// File: doc/key_turn_arbiter.md
KEY_TURN_ARBITER -- requirements
Module: key_turn_arbiter

Interface
REQ-001 Parameter REPEAT_TICKS, default 10, is the auto-repeat period in tick_100hz strobes (100 ms).
REQ-002 Parameter CNT_WIDTH, default 4, is the repeat counter width; it SHALL satisfy 2^CNT_WIDTH > REPEAT_TICKS.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_100hz  input  1  one-clk strobe at 100 Hz, synchronous to clk.
REQ-006 red_s  input  4  short-press pulses {up,dn,lf,rt}, one clk each, red player (W/S/A/D).
REQ-007 red_l  input  4  long-press levels, same bit order, red player.
REQ-008 red_sel  input  1  short-press pulse, red select (left shift).
REQ-009 blk_s, blk_l  input  4 each  as red_s/red_l, black player (arrow keys).
REQ-010 blk_sel  input  1  short-press pulse, black select (right shift).
REQ-011 undo_req  input  1  backspace short pulse, either player.
REQ-012 restart_req  input  1  space short pulse.
REQ-013 move_done  input  1  one-clk pulse from game logic when a piece move completes.
REQ-014 cmd_ready  input  1  game logic accepts the command.
REQ-015 cmd_valid  output  1  command present.
REQ-016 cmd_op  output  3  0=up, 1=dn, 2=lf, 3=rt, 4=select, 5=undo.
REQ-017 cmd_player  output  1  0=red, 1=black; owner of the command.
REQ-018 turn  output  1  current player, 0=red.
REQ-019 history_cnt  output  8  number of completed moves available for undo.

Function
REQ-020 The FSM SHALL have two states: IDLE and ISSUE.
REQ-021 In IDLE, with an accepted event at edge N, the block SHALL register cmd_op/cmd_player, raise cmd_valid at N+1 and enter ISSUE.
REQ-022 Only the inputs of the player equal to turn are accepted; the other player's inputs are dropped, never queued.
REQ-023 Same-cycle event priority SHALL be: undo > select > up > dn > lf > rt > auto-repeat.
REQ-024 undo_req is accepted only when history_cnt > 0; otherwise it is dropped.
REQ-025 In ISSUE, cmd_valid, cmd_op and cmd_player SHALL hold stable until an edge with cmd_ready=1; the next cycle is IDLE with cmd_valid=0.
REQ-026 Events arriving in ISSUE are dropped; the earliest next command is two cycles after the handshake edge.
REQ-027 move_done in IDLE SHALL toggle turn and increment history_cnt, saturating at 255.
REQ-028 move_done in ISSUE SHALL set a pending flag, applied (toggle and increment) on the handshake edge.
REQ-029 A second move_done while pending is already set is ignored.
REQ-030 Handshake of an undo command SHALL toggle turn and decrement history_cnt on the same edge.
REQ-031 If a pending move_done and an undo handshake coincide, both apply: turn is unchanged and history_cnt is unchanged.
REQ-032 Auto-repeat:
- Repeat direction = lowest-index set bit of the current player's *_l.
- Counter increments on tick_100hz while that direction is held.
- On reaching REPEAT_TICKS-1 with a tick, the counter wraps to 0 and a move event for that direction is generated.
REQ-033 The repeat counter SHALL clear when no *_l bit is set, when the repeat direction changes, when turn changes, or on restart.
REQ-034 restart_req overrides everything in any state, effective next cycle:
- turn=0, history_cnt=0, state=IDLE, cmd_valid=0;
- pending flag and repeat counter cleared;
- any unacknowledged command is withdrawn.

Reset
REQ-035 While rst_n=0, outputs SHALL be: cmd_valid=0, cmd_op=0, cmd_player=0, turn=0, history_cnt=0.
REQ-036 While rst_n=0, state SHALL be IDLE, with pending flag and repeat counter at 0.
REQ-037 Reset assertion mid-ISSUE SHALL drop cmd_valid asynchronously.
REQ-038 After reset, the first edge with rst_n=1 SHALL accept events.

Verification
REQ-039 Short press, ready tied 1: turn=0, red_s=4'b0100 at edge N -> cmd_valid=1, op=2, player=0 at N+1, low at N+2.
REQ-040 Wrong player and priority: blk_s pulse while turn=0 -> no cmd_valid. red_sel and red_s[3] in the same cycle -> op=4 only.
REQ-041 Backpressure: cmd_ready=0 for 5 cycles -> command held stable. move_done during the stall -> turn toggles and history_cnt 0->1 on the handshake edge. A red_s pulse during the stall is dropped.
REQ-042 Auto-repeat: red_l=4'b0001 held for 35 ticks -> exactly 3 up commands, 10 ticks apart. Releasing at tick 5 -> none.
REQ-043 Undo: history_cnt=0, undo_req -> no command. After one move, undo handshake -> op=5, history_cnt=0, turn back to 0.
REQ-044 Restart: restart_req mid-ISSUE with history_cnt=7, turn=1 -> next cycle cmd_valid=0, turn=0, history_cnt=0.
